// File: rtl/mp_add_pkg.sv
// Shared types and defaults for the multi-precision adder controller.
//   state_t   : controller state encoding (IDLE / RUN / DONE)
//   DEF_N     : default word width of the shared adder
//   DEF_WORDS : default number of words per operand
package mp_add_pkg;

  localparam int unsigned DEF_N     = 32;
  localparam int unsigned DEF_WORDS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mp_word_add.sv
// N-bit adder with carry-in/carry-out, built as a chain of 4-bit
// carry-lookahead cells.
//   a, b   : N-bit operand words
//   cin    : carry in
//   sum_c  : N-bit sum (combinational)
//   cout_c : carry out (combinational)

// 4-bit carry-lookahead cell.
module mp_cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s_c,
  output logic       co_c
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] cy;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry computed directly from generate/propagate terms.
  assign cy[0] = ci;
  assign cy[1] = g[0] | (p[0] & ci);
  assign cy[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign cy[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & ci);
  assign co_c  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s_c = p ^ cy;

endmodule

module mp_word_add #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum_c,
  output logic         cout_c
);

  localparam int unsigned CELLS = N / 4;

  logic [CELLS:0] cy;

  assign cy[0] = cin;

  // Cells ripple their group carry into the next cell.
  for (genvar i = 0; i < CELLS; i++) begin : g_cell
    mp_cla4 u_cla4 (
      .a    (a[4*i +: 4]),
      .b    (b[4*i +: 4]),
      .ci   (cy[i]),
      .s_c  (sum_c[4*i +: 4]),
      .co_c (cy[i+1])
    );
  end

  assign cout_c = cy[CELLS];

endmodule

// File: rtl/mp_add_ctrl.sv
// Multi-precision adder controller: adds two WORDS*N-bit operands one
// N-bit word per cycle on a single shared adder, least significant first.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : begin an operation (accepted only when not busy)
//   a, b       : operands, sampled on an accepted start
//   busy       : high while words are being processed
//   done       : one-cycle pulse when s/c are valid
//   s, c       : wide sum and final carry out
// Optional macro MP_ADD_SUB_EN adds input sub: a-b via ~b plus carry-in 1.
module mp_add_ctrl
  import mp_add_pkg::*;
#(
  parameter int unsigned N     = DEF_N,
  parameter int unsigned WORDS = DEF_WORDS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [N*WORDS-1:0]   a,
  input  logic [N*WORDS-1:0]   b,
  output logic                 busy,
  output logic                 done,
  output logic [N*WORDS-1:0]   s,
  output logic                 c
`ifdef MP_ADD_SUB_EN
  ,
  input  logic                 sub
`endif
);

  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_t                      state;
  logic [IDX_W-1:0]            idx;
  logic                        carry_q;
  logic [WORDS-1:0][N-1:0]     a_q;
  logic [WORDS-1:0][N-1:0]     b_q;
  logic [WORDS-1:0][N-1:0]     s_q;
  logic [N-1:0]                word_sum;
  logic                        word_cout;
  logic                        sub_w;

`ifdef MP_ADD_SUB_EN
  assign sub_w = sub;
`else
  assign sub_w = 1'b0;
`endif

  // The one shared word adder, fed by the word selected by idx.
  mp_word_add #(.N(N)) u_word_add (
    .a      (a_q[idx]),
    .b      (b_q[idx]),
    .cin    (carry_q),
    .sum_c  (word_sum),
    .cout_c (word_cout)
  );

  // Controller FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      c       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_q     <= a;
            // Subtraction is a + ~b + 1: invert B here, carry-in of 1.
            b_q     <= sub_w ? ~b : b;
            carry_q <= sub_w;
            idx     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          s_q[idx] <= word_sum;
          carry_q  <= word_cout;
          if (idx == LAST_IDX) begin
            // idx stays on the last word; it is reloaded on the next start.
            c     <= word_cout;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign s = s_q;

endmodule

// File: tb/tb_mp_add_ctrl.sv
// Self-checking bench for mp_add_ctrl at N=32, WORDS=4 against a plain
// 129-bit arithmetic reference.
module tb_mp_add_ctrl;

  localparam int unsigned N     = 32;
  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = N * WORDS;
`ifdef MP_ADD_SUB_EN
  localparam bit HAS_SUB = 1'b1;
`else
  localparam bit HAS_SUB = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         c;

  int checks = 0;
  int errors = 0;

  logic [W:0] exp_q[$];

  always #5 clk = ~clk;

  mp_add_ctrl #(.N(N), .WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .c     (c)
`ifdef MP_ADD_SUB_EN
    ,
    .sub   (sub)
`endif
  );

  task automatic check_eq(input string tag, input logic [W:0] got, input logic [W:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input bit is_sub);
    if (is_sub && HAS_SUB) return {1'b0, x} - {1'b0, y} + {1'b1, {W{1'b0}}};
    return {1'b0, x} + {1'b0, y};
  endfunction

  function automatic logic [W-1:0] rand_wide();
    logic [W-1:0] r;
    for (int i = 0; i < WORDS; i++) begin
      case ($urandom_range(0, 3))
        0:       r[i*N +: N] = '1;
        1:       r[i*N +: N] = '0;
        default: r[i*N +: N] = N'($urandom);
      endcase
    end
    return r;
  endfunction

  // One operation; extra_at >= 0 pulses start again that many cycles after acceptance.
  task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input bit tsub, input int extra_at);
    logic [W:0] exp;
    int busy_cnt;
    int lat;
    bit found;
    exp = model(ta, tb, tsub);
    @(negedge clk);
    a = ta; b = tb; sub = tsub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = rand_wide(); b = rand_wide(); sub = 1'($urandom_range(0, 1));
    busy_cnt = 0; lat = -1; found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      if (done) begin
        found = 1'b1;
        lat = k;
      end else begin
        if (busy) busy_cnt++;
        if (k == extra_at) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    check_eq({tag, ".timeout"}, (W+1)'(found), (W+1)'(1));
    check_eq({tag, ".latency"}, (W+1)'(lat), (W+1)'(WORDS));
    check_eq({tag, ".busy_cycles"}, (W+1)'(busy_cnt), (W+1)'(WORDS));
    check_eq({tag, ".sum"}, {c, s}, exp);
    @(posedge clk); #1;
    check_eq({tag, ".done_pulse"}, (W+1)'(done), (W+1)'(0));
    check_eq({tag, ".hold"}, {c, s}, exp);
  endtask

  initial begin
    logic [W:0] got_exp;
    int dones;
    int last_done;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset.busy", (W+1)'(busy), (W+1)'(0));
    check_eq("reset.done", (W+1)'(done), (W+1)'(0));
    check_eq("reset.sc", {c, s}, '0);
    rst_n = 1'b1;

    do_op("one_plus_one", W'(1), W'(1), 1'b0, -1);
    do_op("ripple_all", {W{1'b1}}, W'(1), 1'b0, -1);
    do_op("ignored_start", {32'h1, {96{1'b1}}}, W'(1), 1'b0, 1);

    // Reset during a run: operands of the aborted op are irrelevant.
    @(negedge clk);
    a = rand_wide(); b = rand_wide(); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check_eq("midrst.busy", (W+1)'(busy), (W+1)'(0));
      check_eq("midrst.done", (W+1)'(done), (W+1)'(0));
      check_eq("midrst.sc", {c, s}, '0);
    end
    rst_n = 1'b1;
    do_op("after_reset", W'(5), W'(7), 1'b0, -1);

`ifdef MP_ADD_SUB_EN
    do_op("sub_borrow", W'(3), W'(5), 1'b1, -1);
    do_op("sub_noborrow", W'(5), W'(3), 1'b1, -1);
`endif

    for (int i = 0; i < 16; i++) begin
      do_op("random", rand_wide(), rand_wide(), 1'($urandom_range(0, 1)), -1);
    end

    // Back-to-back: start held high, each done must be WORDS+1 cycles apart.
    @(negedge clk);
    a = rand_wide(); b = rand_wide(); sub = 1'($urandom_range(0, 1));
    exp_q.push_back(model(a, b, sub));
    start = 1'b1;
    dones = 0; last_done = -1;
    for (int k = 0; k < 60 && dones < 8; k++) begin
      @(posedge clk); #1;
      if (done) begin
        got_exp = exp_q.pop_front();
        check_eq("b2b.sum", {c, s}, got_exp);
        if (last_done >= 0) check_eq("b2b.interval", (W+1)'(k - last_done), (W+1)'(WORDS + 1));
        last_done = k;
        dones++;
        if (dones < 8) begin
          a = rand_wide(); b = rand_wide(); sub = 1'($urandom_range(0, 1));
          exp_q.push_back(model(a, b, sub));
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check_eq("b2b.count", (W+1)'(dones), (W+1)'(8));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
